// File: rtl/program_loader.sv
// Byte-stream program loader: takes a 16-bit word count followed by little-endian
// instruction bytes and writes 32-bit words sequentially into instruction memory.
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  prog_ready,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state_reg;
  logic [7:0]  len_lo_reg;
  logic [15:0] len_reg;
  logic [15:0] word_idx_reg;
  logic [1:0]  byte_idx_reg;
  logic [7:0]  asm_reg [0:2];

  logic        accept;
  logic [15:0] hdr_len;

  assign accept  = rx_valid && rx_ready;
  assign hdr_len = {rx_data, len_lo_reg};

  // rx_ready is registered: each transition sets it for the state being entered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= LEN_LO;
      len_lo_reg   <= '0;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      for (int k = 0; k < 3; k++) asm_reg[k] <= '0;
      rx_ready     <= 1'b0;
      w_en         <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      prog_ready   <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      w_en     <= 1'b0;
      rx_ready <= 1'b1;
      case (state_reg)
        LEN_LO: begin
          if (start) begin
            words_loaded <= '0;
          end else if (accept) begin
            len_lo_reg <= rx_data;
            state_reg  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (start) begin
            words_loaded <= '0;
            state_reg    <= LEN_LO;
          end else if (accept) begin
            len_reg <= hdr_len;
            if (hdr_len == 16'd0) begin
              prog_ready <= 1'b1;
              rx_ready   <= 1'b0;
              state_reg  <= DONE;
            end else if (hdr_len > 16'(MEM_DEPTH)) begin
              load_error <= 1'b1;
              rx_ready   <= 1'b0;
              state_reg  <= ERROR;
            end else begin
              byte_idx_reg <= '0;
              word_idx_reg <= '0;
              words_loaded <= '0;
              state_reg    <= DATA;
            end
          end
        end

        DATA: begin
          if (start) begin
            byte_idx_reg <= '0;
            words_loaded <= '0;
            state_reg    <= LEN_LO;
          end else if (accept) begin
            if (byte_idx_reg == 2'd3) begin
              w_en      <= 1'b1;
              w_addr    <= {word_idx_reg[ADDR_WIDTH-3:0], 2'b00};
              w_data    <= {rx_data, asm_reg[2], asm_reg[1], asm_reg[0]};
              rx_ready  <= 1'b0;
              state_reg <= WRITE;
            end else begin
              for (int k = 0; k < 3; k++) begin
                if (byte_idx_reg == 2'(k)) asm_reg[k] <= rx_data;
              end
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end

        WRITE: begin
          // The write already went out this cycle, so a start here still counts it.
          word_idx_reg <= word_idx_reg + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          byte_idx_reg <= '0;
          if (start) begin
            state_reg <= LEN_LO;
          end else if (word_idx_reg + 16'd1 == len_reg) begin
            prog_ready <= 1'b1;
            rx_ready   <= 1'b0;
            state_reg  <= DONE;
          end else begin
            state_reg <= DATA;
          end
        end

        DONE: begin
          if (start) begin
            prog_ready   <= 1'b0;
            words_loaded <= '0;
            state_reg    <= LEN_LO;
          end else begin
            rx_ready <= 1'b0;
          end
        end

        ERROR: begin
          if (start) begin
            load_error   <= 1'b0;
            words_loaded <= '0;
            state_reg    <= LEN_LO;
          end else begin
            rx_ready <= 1'b0;
          end
        end

        default: begin
          rx_ready  <= 1'b0;
          state_reg <= LEN_LO;
        end
      endcase
    end
  end

endmodule
